mem_pipe_ctrl: RTL
==================

Name: mem_pipe_ctrl

Overview:
- Main-memory front end that sits directly downstream of the cache fill FSM.
- Accepts word read requests from the fill FSM, up to one per cycle, and returns each word with a fixed latency and a valid strobe. That strobe is the fill FSM's memory_data_valid.
- Also accepts D-cache write-through stores.
- Drives one single-port synchronous SRAM and holds a one-entry write buffer with read forwarding.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 16: word width.
- IDX_W, 15: SRAM word-index width; index = addr[IDX_W:1].
- LATENCY, 4: cycles from read acceptance to data_valid; legal range 2..8.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read byte address; bit 0 ignored.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write byte address; bit 0 ignored.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle when wr_en=1.
- data_valid  out  1  data_out holds the word for the read accepted LATENCY cycles earlier.
- data_out  out  DATA_W  returned read word.
- busy  out  1  at least one read in flight, or the write buffer is full.
- sram_addr  out  IDX_W  SRAM word index.
- sram_we  out  1  SRAM write enable.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after the read address.

Behaviour:
- Reset (rst=0, async):
  - Clear all pipeline valid bits and the write-buffer valid bit; any buffered write is discarded.
  - data_valid=0, data_out=0, busy=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - wr_ready is combinational; it is 1 during reset because the buffer is empty.
- Reads are always accepted; there is no read backpressure, and rd_en=1 in a cycle T means accepted.
- Read at T:
  - Uses the SRAM port at T.
  - sram_rdata is captured into pipe stage 1 at T+1, then shifted through LATENCY-1 valid/data registers.
  - data_valid=1 and data_out=word, both registered, at cycle T+LATENCY exactly.
- Back-to-back reads stream at one word per cycle, in order. An 8-word fill gives 8 consecutive data_valid cycles.
- Forwarding:
  - Applies when, at the start of T, the buffer is valid and its index equals rd_addr[IDX_W:1].
  - The buffer data is injected instead of sram_rdata; latency is still exactly LATENCY.
- Read and write in the same cycle to the same index: the read is ordered first and returns the pre-write value.
- Port arbitration each cycle, in priority order:
  1. rd_en=1: the read owns the port. If wr_en=1 and the buffer is empty, the write goes to the buffer and wr_ready=1. If wr_en=1 and the buffer is full, wr_ready=0 and the requester holds.
  2. rd_en=0, buffer full: the buffer drains to the SRAM (sram_we=1). If wr_en=1, the new write enters the buffer in the same cycle (wr_ready=1).
  3. rd_en=0, buffer empty, wr_en=1: write straight to the SRAM; wr_ready=1.
  4. Otherwise the port is idle; sram_we=0 and sram_addr holds its last value.
- Writes reach the SRAM in acceptance order.
- wr_ready = ~(buf_valid & rd_en).
- busy = OR of pipe valids, OR buf_valid. It is registered-derived, with no combinational path from inputs.
- sram_addr, sram_we, sram_wdata are combinational from arbitration; the SRAM registers them.
- Reset mid-fill: in-flight reads are dropped, and no data_valid is produced after reset releases.

Test Plan:
- Reset: hold rst=0 with rd_en=1 -> data_valid=0, busy=0, sram_we=0. Release rst, issue a read at 0x0010 with SRAM word 8 = 0xBEEF -> data_valid exactly 4 cycles later, data_out=0xBEEF.
- Burst: 8 consecutive reads 0x0100..0x010E -> 8 consecutive data_valid cycles, in order, starting 4 cycles after the first read, no gaps; busy falls the cycle after the last word.
- Collision and forwarding:
  - Read 0x0200 and write 0x0300=0x1234 in the same cycle -> write buffered, wr_ready=1, sram_we=0.
  - Next cycle read 0x0300 -> returns 0x1234.
  - First idle cycle -> sram_we=1, sram_addr=0x180.
- Stall: buffer full, then rd_en=1 & wr_en=1 -> wr_ready=0. Drop rd_en -> buffer drains and the new write is accepted the same cycle (wr_ready=1).
- Same-cycle same-address: memory word 0x40 = 0xAAAA; read and write 0x0080=0x5555 in the same cycle -> read returns 0xAAAA; a later read returns 0x5555.
- Reset mid-burst: assert rst=0 after 3 of 8 reads -> no data_valid ever appears for them; buffered write lost; busy=0.

Source files
------------

// File: rtl/mem_pipe_ctrl.sv
// rtl/mem_pipe_ctrl.sv - main-memory front end: fixed-latency read pipe, one-entry write buffer with forwarding
module mem_pipe_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 15,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic [IDX_W-1:0]  sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic              buf_valid;
  logic [IDX_W-1:0]  buf_idx;
  logic [DATA_W-1:0] buf_data;

  logic [IDX_W-1:0]  last_addr;
  logic [DATA_W-1:0] last_wdata;

  // Cycle after acceptance: SRAM is producing the word, or forwarded data is parked here
  logic              req_valid;
  logic              req_fwd;
  logic [DATA_W-1:0] req_data;

  logic [LATENCY-1:1] pipe_valid;
  logic [DATA_W-1:0]  pipe_data [1:LATENCY-1];

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              drain;
  logic              buf_load;
  logic              fwd_hit;
  logic [IDX_W-1:0]  port_addr;
  logic              port_we;
  logic [DATA_W-1:0] port_wdata;
  logic              unused_addr_lsb;

  assign rd_idx          = rd_addr[IDX_W:1];
  assign wr_idx          = wr_addr[IDX_W:1];
  assign unused_addr_lsb = rd_addr[0] ^ wr_addr[0];

  always_comb begin
    drain    = !rd_en && buf_valid;
    buf_load = wr_en && (rd_en ? !buf_valid : buf_valid);
    fwd_hit  = buf_valid && (buf_idx == rd_idx);
  end

  // Read beats buffer drain beats direct write; an idle port keeps its last address
  always_comb begin
    port_addr  = last_addr;
    port_we    = 1'b0;
    port_wdata = last_wdata;
    if (rd_en) begin
      port_addr = rd_idx;
    end else if (buf_valid) begin
      port_we    = 1'b1;
      port_addr  = buf_idx;
      port_wdata = buf_data;
    end else if (wr_en) begin
      port_we    = 1'b1;
      port_addr  = wr_idx;
      port_wdata = wr_data;
    end
  end

  assign sram_we    = rst & port_we;
  assign sram_addr  = rst ? port_addr : '0;
  assign sram_wdata = rst ? port_wdata : '0;

  assign wr_ready   = ~(buf_valid & rd_en);
  assign busy       = req_valid | (|pipe_valid) | buf_valid;
  assign data_valid = pipe_valid[LATENCY-1];
  assign data_out   = pipe_data[LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid  <= 1'b0;
      buf_idx    <= '0;
      buf_data   <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
      req_valid  <= 1'b0;
      req_fwd    <= 1'b0;
      req_data   <= '0;
      pipe_valid <= '0;
      for (int i = 1; i < LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      req_valid <= rd_en;
      req_fwd   <= rd_en && fwd_hit;
      req_data  <= buf_data;

      if (rd_en || port_we) last_addr <= port_addr;
      if (port_we) last_wdata <= port_wdata;

      if (buf_load) begin
        buf_valid <= 1'b1;
        buf_idx   <= wr_idx;
        buf_data  <= wr_data;
      end else if (drain) begin
        buf_valid <= 1'b0;
      end

      pipe_valid[1] <= req_valid;
      pipe_data[1]  <= req_fwd ? req_data : sram_rdata;
      for (int i = 2; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

endmodule
